// File: rtl/alu_host_sequencer_pkg.sv
// Shared state encoding, frame layout constants and the frame byte selector
// for the ALU host sequencer.
package alu_host_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_TX_SEND = 3'd1;
  localparam logic [2:0] ST_TX_WAIT = 3'd2;
  localparam logic [2:0] ST_RX_WAIT = 3'd3;
  localparam logic [2:0] ST_RESP    = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    TX_SEND = ST_TX_SEND,
    TX_WAIT = ST_TX_WAIT,
    RX_WAIT = ST_RX_WAIT,
    RESP    = ST_RESP
  } state_t;

  localparam int FRAME_LEN = 5;
  localparam int RSP_LEN   = 2;

  localparam logic [2:0] IDX_INS   = 3'd0;
  localparam logic [2:0] IDX_A_MSB = 3'd1;
  localparam logic [2:0] IDX_A_LSB = 3'd2;
  localparam logic [2:0] IDX_B_MSB = 3'd3;
  localparam logic [2:0] IDX_B_LSB = 3'd4;

  // Operands go out MSB byte first so the sign travels in the first byte.
  function automatic logic [7:0] frame_byte(input logic [7:0]  ins,
                                            input logic [15:0] a,
                                            input logic [15:0] b,
                                            input logic [2:0]  idx);
    frame_byte = 8'h00;
    case (idx)
      IDX_INS:   frame_byte = ins;
      IDX_A_MSB: frame_byte = a[15:8];
      IDX_A_LSB: frame_byte = a[7:0];
      IDX_B_MSB: frame_byte = b[15:8];
      IDX_B_LSB: frame_byte = b[7:0];
      default:   frame_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/alu_host_sequencer_if.sv
// Request, UART TX/RX and response signals of the ALU host sequencer.
// slave is the sequencer side, master is the request source / UART side.
interface alu_host_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_ins;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        tx_done;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        rsp_valid;
  logic [15:0] rsp_c;
  logic        rsp_timeout;
  logic        busy;

  modport slave (
    input  req_valid, req_ins, req_a, req_b, tx_done, rx_dv, rx_byte,
    output req_ready, tx_dv, tx_byte, rsp_valid, rsp_c, rsp_timeout, busy
  );

  modport master (
    output req_valid, req_ins, req_a, req_b, tx_done, rx_dv, rx_byte,
    input  req_ready, tx_dv, tx_byte, rsp_valid, rsp_c, rsp_timeout, busy
  );
endinterface

// File: rtl/alu_host_sequencer_timeout.sv
// Loadable down-counter for the result wait; expired is high while enabled
// at zero. Only instantiated when ALU_HOST_SEQ_TIMEOUT_EN is defined.
module alu_host_timeout #(
  parameter logic [23:0] LOAD_VALUE = 24'd15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load,
  input  logic enable,
  output logic expired
);

  logic [23:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              count <= 24'd0;
    else if (clear)                       count <= 24'd0;
    else if (load)                        count <= LOAD_VALUE;
    else if (enable && count != 24'd0)    count <= count - 24'd1;
  end

  assign expired = enable && (count == 24'd0);

endmodule

// File: rtl/alu_host_sequencer.sv
// Serialises one ALU request into a 5-byte UART frame and reassembles the
// 2-byte result. Optional result timeout: ALU_HOST_SEQ_TIMEOUT_EN.
module alu_host_sequencer
  import alu_host_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
  input logic                 clk,
  input logic                 rst,
  alu_host_sequencer_if.slave bus
);

  state_t      state, state_next;
  logic [2:0]  idx, idx_next;
  logic        rcnt, rcnt_next;
  logic [7:0]  ins_q, ins_next;
  logic [15:0] a_q, a_next, b_q, b_next;
  logic [7:0]  c_hi, c_hi_next;
  logic        ready_q, tx_dv_q, rsp_valid_q, rsp_timeout_q, busy_q;
  logic [7:0]  tx_byte_q, tx_byte_next;
  logic [15:0] rsp_c_q, rsp_c_next;
  logic        timeout_next;
  logic        tmr_load;
  logic        expired;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= 3'd0;
      rcnt          <= 1'b0;
      ins_q         <= 8'h00;
      a_q           <= 16'h0000;
      b_q           <= 16'h0000;
      c_hi          <= 8'h00;
      ready_q       <= 1'b0;
      tx_dv_q       <= 1'b0;
      tx_byte_q     <= 8'h00;
      rsp_valid_q   <= 1'b0;
      rsp_c_q       <= 16'h0000;
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state         <= state_next;
      idx           <= idx_next;
      rcnt          <= rcnt_next;
      ins_q         <= ins_next;
      a_q           <= a_next;
      b_q           <= b_next;
      c_hi          <= c_hi_next;
      ready_q       <= (state_next == IDLE);
      tx_dv_q       <= (state_next == TX_SEND);
      tx_byte_q     <= tx_byte_next;
      rsp_valid_q   <= (state_next == RESP);
      rsp_c_q       <= rsp_c_next;
      rsp_timeout_q <= timeout_next;
      busy_q        <= (state_next != IDLE);
    end
  end

  // A received byte takes priority over a timeout expiring in the same cycle.
  always_comb begin
    state_next   = state;
    idx_next     = idx;
    rcnt_next    = rcnt;
    ins_next     = ins_q;
    a_next       = a_q;
    b_next       = b_q;
    c_hi_next    = c_hi;
    rsp_c_next   = rsp_c_q;
    timeout_next = 1'b0;
    tmr_load     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid && ready_q) begin
          ins_next   = bus.req_ins;
          a_next     = bus.req_a;
          b_next     = bus.req_b;
          idx_next   = IDX_INS;
          state_next = TX_SEND;
        end
      end
      TX_SEND: state_next = TX_WAIT;
      TX_WAIT: begin
        if (bus.tx_done) begin
          if (idx == 3'(FRAME_LEN - 1)) begin
            rcnt_next  = 1'b0;
            tmr_load   = 1'b1;
            state_next = RX_WAIT;
          end else begin
            idx_next   = idx + 3'd1;
            state_next = TX_SEND;
          end
        end
      end
      RX_WAIT: begin
        if (bus.rx_dv) begin
          tmr_load = 1'b1;
          if (rcnt == 1'(RSP_LEN - 1)) begin
            rsp_c_next = {c_hi, bus.rx_byte};
            state_next = RESP;
          end else begin
            c_hi_next = bus.rx_byte;
            rcnt_next = 1'b1;
          end
        end else if (expired) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    tx_byte_next = tx_byte_q;
    if (state_next == TX_SEND)
      tx_byte_next = frame_byte(ins_next, a_next, b_next, idx_next);
  end

`ifdef ALU_HOST_SEQ_TIMEOUT_EN
  alu_host_timeout #(.LOAD_VALUE(TIMEOUT_CYCLES - 24'd1)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == IDLE),
    .load    (tmr_load),
    .enable  (state == RX_WAIT),
    .expired (expired)
  );
`else
  logic unused_timeout;
  assign expired        = 1'b0;
  assign unused_timeout = ^{TIMEOUT_CYCLES, tmr_load};
`endif

  assign bus.req_ready   = ready_q;
  assign bus.tx_dv       = tx_dv_q;
  assign bus.tx_byte     = tx_byte_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_c       = rsp_c_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_alu_host_sequencer.sv
// Directed self-checking bench for alu_host_sequencer; the timeout scenarios
// run only when ALU_HOST_SEQ_TIMEOUT_EN is defined.
module tb_alu_host_sequencer;

  logic clk;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   accept_cnt = 0;
  int   valid_cnt = 0;
  int   timeout_cnt = 0;
  int   ready_edges = 0;

  alu_host_sequencer_if bus ();

  alu_host_sequencer #(.TIMEOUT_CYCLES(24'd16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running event counters; tests compare snapshots.
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.req_valid && bus.req_ready) accept_cnt++;
      if (bus.rsp_valid) valid_cnt++;
      if (bus.rsp_timeout) timeout_cnt++;
      if (bus.req_ready) ready_edges++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_request(input logic [7:0] ins, input logic [15:0] a, input logic [15:0] b);
    bus.req_valid = 1'b1;
    bus.req_ins   = ins;
    bus.req_a     = a;
    bus.req_b     = b;
    tick;
    bus.req_valid = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] value);
    bus.rx_dv   = 1'b1;
    bus.rx_byte = value;
    tick;
    bus.rx_dv   = 1'b0;
  endtask

  // Plays the UART TX: captures each strobed byte, holds a few cycles, then
  // answers with tx_done. Optionally injects a stray rx byte during TX_WAIT.
  task automatic run_tx_frame(input int nbytes, input bit stray, output logic [39:0] seen,
                              output int strobes, output int unstable, output int missing);
    seen = '0; strobes = 0; unstable = 0; missing = 0;
    for (int k = 0; k < nbytes; k++) begin
      int n;
      logic [7:0] cur;
      n = 0;
      while (bus.tx_dv !== 1'b1 && n < 20) begin
        tick;
        n++;
      end
      if (bus.tx_dv !== 1'b1) missing++;
      cur = bus.tx_byte;
      seen = {seen[31:0], cur};
      strobes++;
      for (int w = 0; w < 3; w++) begin
        if (stray && k == 1 && w == 1) begin
          bus.rx_dv   = 1'b1;
          bus.rx_byte = 8'hAA;
        end
        tick;
        bus.rx_dv = 1'b0;
        if (bus.tx_dv === 1'b1) strobes++;
        if (bus.tx_byte !== cur) unstable++;
      end
      bus.tx_done = 1'b1;
      tick;
      bus.tx_done = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got %b want 0", bus.req_ready); end
    checks++; if (bus.tx_dv !== 1'b0) begin failures++; $display("[TB] FAIL reset_tx_dv got %b want 0", bus.tx_dv); end
    checks++; if (bus.tx_byte !== 8'h00) begin failures++; $display("[TB] FAIL reset_tx_byte got %h want 00", bus.tx_byte); end
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_c !== 16'h0000) begin failures++; $display("[TB] FAIL reset_rsp_c got %h want 0000", bus.rsp_c); end
    checks++; if (bus.rsp_timeout !== 1'b0) begin failures++; $display("[TB] FAIL reset_timeout got %b want 0", bus.rsp_timeout); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
    rst = 1'b0;
    tick;
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("[TB] FAIL idle_ready got %b want 1", bus.req_ready); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_frame;
    logic [39:0] seen;
    int strobes, unstable, missing;
    send_request(8'h01, 16'h0018, 16'hFFF8);
    checks++; if (bus.tx_dv !== 1'b1) begin failures++; $display("[TB] FAIL frame_first_strobe got %b want 1", bus.tx_dv); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL frame_busy got %b want 1", bus.busy); end
    run_tx_frame(5, 1'b0, seen, strobes, unstable, missing);
    checks++; if (seen !== 40'h010018FFF8) begin failures++; $display("[TB] FAIL frame_bytes got %h want 010018fff8", seen); end
    checks++; if (strobes !== 5 || missing !== 0) begin failures++; $display("[TB] FAIL frame_strobes got %0d (missing %0d) want 5", strobes, missing); end
    checks++; if (unstable !== 0) begin failures++; $display("[TB] FAIL frame_hold got %0d changes want 0", unstable); end
    send_rx(8'h00);
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL frame_early_valid got %b want 0", bus.rsp_valid); end
    send_rx(8'h10);
    checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("[TB] FAIL frame_valid got %b want 1", bus.rsp_valid); end
    checks++; if (bus.rsp_c !== 16'h0010) begin failures++; $display("[TB] FAIL frame_result got %h want 0010", bus.rsp_c); end
    tick;
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL frame_valid_pulse got %b want 0", bus.rsp_valid); end
    checks++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL frame_return_idle got ready=%b busy=%b want 1/0", bus.req_ready, bus.busy); end
  endtask

  task automatic test_back_to_back;
    logic [39:0] seen;
    int strobes, unstable, missing, a0, r0;
    a0 = accept_cnt;
    bus.req_valid = 1'b1;
    bus.req_ins   = 8'h02;
    bus.req_a     = 16'h8000;
    bus.req_b     = 16'h7FFF;
    tick;
    r0 = ready_edges;
    run_tx_frame(5, 1'b0, seen, strobes, unstable, missing);
    checks++; if (seen !== 40'h0280007FFF) begin failures++; $display("[TB] FAIL b2b_bytes1 got %h want 0280007fff", seen); end
    send_rx(8'h80);
    send_rx(8'h01);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_c !== 16'h8001) begin failures++; $display("[TB] FAIL b2b_result1 got valid=%b c=%h want 1/8001", bus.rsp_valid, bus.rsp_c); end
    checks++; if (ready_edges !== r0 || bus.req_ready !== 1'b0) begin failures++; $display("[TB] FAIL b2b_ready_low got %0d ready edges want 0", ready_edges - r0); end
    checks++; if (accept_cnt !== a0 + 1) begin failures++; $display("[TB] FAIL b2b_accepts1 got %0d want 1", accept_cnt - a0); end
    tick;
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready_after got %b want 1", bus.req_ready); end
    tick;
    bus.req_valid = 1'b0;
    checks++; if (accept_cnt !== a0 + 2 || bus.tx_dv !== 1'b1) begin failures++; $display("[TB] FAIL b2b_accepts2 got %0d tx_dv=%b want 2/1", accept_cnt - a0, bus.tx_dv); end
    run_tx_frame(5, 1'b0, seen, strobes, unstable, missing);
    checks++; if (seen !== 40'h0280007FFF || strobes !== 5) begin failures++; $display("[TB] FAIL b2b_bytes2 got %h (%0d strobes) want 0280007fff", seen, strobes); end
    send_rx(8'hFF);
    send_rx(8'hFF);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_c !== 16'hFFFF) begin failures++; $display("[TB] FAIL b2b_result2 got valid=%b c=%h want 1/ffff", bus.rsp_valid, bus.rsp_c); end
    tick;
  endtask

  task automatic test_stray_rx;
    logic [39:0] seen;
    int strobes, unstable, missing, v0, t0;
    v0 = valid_cnt;
    t0 = timeout_cnt;
    send_rx(8'h5A);
    checks++; if (bus.busy !== 1'b0 || valid_cnt !== v0) begin failures++; $display("[TB] FAIL stray_idle got busy=%b pulses=%0d want 0/0", bus.busy, valid_cnt - v0); end
    send_request(8'h03, 16'h0001, 16'h0002);
    run_tx_frame(5, 1'b1, seen, strobes, unstable, missing);
    checks++; if (seen !== 40'h0300010002 || strobes !== 5) begin failures++; $display("[TB] FAIL stray_bytes got %h (%0d strobes) want 0300010002", seen, strobes); end
`ifndef ALU_HOST_SEQ_TIMEOUT_EN
    repeat (40) tick;
    checks++; if (bus.busy !== 1'b1 || timeout_cnt !== t0) begin failures++; $display("[TB] FAIL stray_wait got busy=%b timeouts=%0d want 1/0", bus.busy, timeout_cnt - t0); end
`endif
    send_rx(8'h12);
    send_rx(8'h34);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_c !== 16'h1234) begin failures++; $display("[TB] FAIL stray_result got valid=%b c=%h want 1/1234", bus.rsp_valid, bus.rsp_c); end
    checks++; if (valid_cnt !== v0 || timeout_cnt !== t0) begin failures++; $display("[TB] FAIL stray_no_extra got %0d pulses want 0 before result", valid_cnt - v0); end
    tick;
  endtask

  task automatic test_reset_midframe;
    logic [39:0] seen;
    int strobes, unstable, missing, v0;
    send_request(8'h05, 16'h0102, 16'h0304);
    run_tx_frame(3, 1'b0, seen, strobes, unstable, missing);
    checks++; if (seen[23:0] !== 24'h050102) begin failures++; $display("[TB] FAIL mid_bytes got %h want 050102", seen[23:0]); end
    rst = 1'b1;
    #1;
    checks++; if (bus.tx_dv !== 1'b0 || bus.tx_byte !== 8'h00) begin failures++; $display("[TB] FAIL mid_tx_reset got dv=%b byte=%h want 0/00", bus.tx_dv, bus.tx_byte); end
    checks++; if (bus.busy !== 1'b0 || bus.req_ready !== 1'b0) begin failures++; $display("[TB] FAIL mid_state_reset got busy=%b ready=%b want 0/0", bus.busy, bus.req_ready); end
    checks++; if (bus.rsp_c !== 16'h0000 || bus.rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_rsp_reset got c=%h valid=%b want 0000/0", bus.rsp_c, bus.rsp_valid); end
    tick;
    rst = 1'b0;
    v0 = valid_cnt;
    tick;
    repeat (10) tick;
    checks++; if (valid_cnt !== v0 || bus.req_ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_no_response got %0d pulses ready=%b want 0/1", valid_cnt - v0, bus.req_ready); end
    send_request(8'h07, 16'h0809, 16'h0A0B);
    run_tx_frame(5, 1'b0, seen, strobes, unstable, missing);
    checks++; if (seen !== 40'h0708090A0B || strobes !== 5) begin failures++; $display("[TB] FAIL mid_restart got %h (%0d strobes) want 0708090a0b", seen, strobes); end
    send_rx(8'h00);
    send_rx(8'h01);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_c !== 16'h0001) begin failures++; $display("[TB] FAIL mid_result got valid=%b c=%h want 1/0001", bus.rsp_valid, bus.rsp_c); end
    tick;
  endtask

`ifdef ALU_HOST_SEQ_TIMEOUT_EN
  task automatic test_timeout;
    logic [39:0] seen;
    int strobes, unstable, missing, v0, n;
    bit found;
    v0 = valid_cnt;
    send_request(8'h09, 16'h0000, 16'h0000);
    run_tx_frame(5, 1'b0, seen, strobes, unstable, missing);
    send_rx(8'h55);
    n = 0;
    found = 1'b0;
    while (!found && n < 40) begin
      tick;
      n++;
      if (bus.rsp_timeout === 1'b1) found = 1'b1;
    end
    checks++; if (!found || n !== 16) begin failures++; $display("[TB] FAIL timeout_delay got %0d cycles (seen=%b) want 16", n, found); end
    checks++; if (bus.rsp_c !== 16'h0001 || valid_cnt !== v0) begin failures++; $display("[TB] FAIL timeout_rsp got c=%h pulses=%0d want 0001/0", bus.rsp_c, valid_cnt - v0); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL timeout_busy got %b want 0", bus.busy); end
    tick;
    checks++; if (bus.rsp_timeout !== 1'b0 || bus.req_ready !== 1'b1) begin failures++; $display("[TB] FAIL timeout_pulse got timeout=%b ready=%b want 0/1", bus.rsp_timeout, bus.req_ready); end
  endtask

  task automatic test_rx_at_expiry;
    logic [39:0] seen;
    int strobes, unstable, missing, t0;
    t0 = timeout_cnt;
    send_request(8'h0A, 16'h0000, 16'h0000);
    run_tx_frame(5, 1'b0, seen, strobes, unstable, missing);
    repeat (15) tick;
    send_rx(8'h66);
    checks++; if (bus.rsp_timeout !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL expiry_byte_wins got timeout=%b busy=%b want 0/1", bus.rsp_timeout, bus.busy); end
    send_rx(8'h77);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_c !== 16'h6677) begin failures++; $display("[TB] FAIL expiry_result got valid=%b c=%h want 1/6677", bus.rsp_valid, bus.rsp_c); end
    checks++; if (timeout_cnt !== t0) begin failures++; $display("[TB] FAIL expiry_no_timeout got %0d pulses want 0", timeout_cnt - t0); end
    tick;
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_ins   = 8'h00;
    bus.req_a     = 16'h0000;
    bus.req_b     = 16'h0000;
    bus.tx_done   = 1'b0;
    bus.rx_dv     = 1'b0;
    bus.rx_byte   = 8'h00;
    test_reset;
    test_frame;
    test_back_to_back;
    test_stray_rx;
    test_reset_midframe;
`ifdef ALU_HOST_SEQ_TIMEOUT_EN
    test_timeout;
    test_rx_at_expiry;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation did not finish within 500000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
